// File: rtl/mips_branch_resolver_if.sv
// Branch-resolver bus: the branch request from the decode stage plus the
// registered outcome and statistics returned to the PC-select/flush logic.
//
// Handshake: a branch transfers on a rising edge where in_valid = 1,
// stall = 0 and flush = 0. stall acts as the inverse of ready: while it is
// high nothing is accepted and upstream must re-present the branch. flush
// discards the presented branch and the current result. out_valid marks
// one registered result per accepted branch, held stable while stalled.
interface mips_branch_resolver_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) ();
    logic                 in_valid;
    logic                 stall;
    logic                 flush;
    logic [2:0]           mode;
    logic [WIDTH-1:0]     data1;
    logic [WIDTH-1:0]     data2;
    logic                 pred_taken;
    logic                 out_valid;
    logic                 taken;
    logic                 mispredict;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    // Upstream side: presents branches, observes results.
    modport master (
        output in_valid, stall, flush, mode, data1, data2, pred_taken,
        input  out_valid, taken, mispredict, branch_cnt, mispred_cnt
    );

    // Resolver side.
    modport slave (
        input  in_valid, stall, flush, mode, data1, data2, pred_taken,
        output out_valid, taken, mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/mips_branch_resolver.sv
// Registered branch-condition unit at the ID/EX boundary. Evaluates one of
// eight conditions on rs/rt, registers the outcome with the fetch-stage
// prediction, flags mispredictions and keeps saturating statistics.
module mips_branch_resolver #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_branch_resolver_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 cond;
    logic                 out_valid_r;
    logic                 taken_r;
    logic                 pred_r;
    logic [CNT_WIDTH-1:0] branch_cnt_r;
    logic [CNT_WIDTH-1:0] mispred_cnt_r;
    logic                 load;

    // A branch is accepted only when neither stalled nor flushed.
    assign load = bus.in_valid & ~bus.stall & ~bus.flush;

    // Condition evaluation; signed modes use the full-width two's complement
    // value with the MSB as sign, zero tests ignore data2.
    always_comb begin
        cond = 1'b0;
        case (bus.mode)
            3'b000:  cond = (bus.data1 == bus.data2);
            3'b001:  cond = (bus.data1 != bus.data2);
            3'b010:  cond = ($signed(bus.data1) <  $signed(bus.data2));
            3'b011:  cond = ($signed(bus.data1) >= $signed(bus.data2));
            3'b100:  cond = (bus.data1 <  bus.data2);
            3'b101:  cond = (bus.data1 >= bus.data2);
            3'b110:  cond = bus.data1[WIDTH-1] | (bus.data1 == '0);
            3'b111:  cond = ~bus.data1[WIDTH-1] & (bus.data1 != '0);
            default: cond = 1'b0;
        endcase
    end

    // Output register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            taken_r     <= 1'b0;
            pred_r      <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (!bus.stall) begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                taken_r <= cond;
                pred_r  <= bus.pred_taken;
            end
        end
    end

    // Statistics: each counter saturates on its own, never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else if (load) begin
            if (branch_cnt_r != CNT_MAX)
                branch_cnt_r <= branch_cnt_r + 1'b1;
            if ((cond != bus.pred_taken) && (mispred_cnt_r != CNT_MAX))
                mispred_cnt_r <= mispred_cnt_r + 1'b1;
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.taken       = out_valid_r & taken_r;
    assign bus.mispredict  = out_valid_r & (taken_r ^ pred_r);
    assign bus.branch_cnt  = branch_cnt_r;
    assign bus.mispred_cnt = mispred_cnt_r;
endmodule

// File: tb/tb_mips_branch_resolver.sv
// Directed bench for mips_branch_resolver: a 32-bit/16-bit-counter instance
// for conditions and protocol, and a 2-bit-counter instance for saturation.
module tb_mips_branch_resolver;
    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    mips_branch_resolver_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();
    mips_branch_resolver_if #(.WIDTH(32), .CNT_WIDTH(2))  bus2 ();

    mips_branch_resolver #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mips_branch_resolver #(.WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Clock generation.
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        pred;
        logic        exp_taken;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ov, input logic tk, input logic mp,
                             input logic [15:0] bc, input logic [15:0] mc);
        check({tag, " out_valid"},   32'(bus.out_valid),   32'(ov));
        check({tag, " taken"},       32'(bus.taken),       32'(tk));
        check({tag, " mispredict"},  32'(bus.mispredict),  32'(mp));
        check({tag, " branch_cnt"},  32'(bus.branch_cnt),  32'(bc));
        check({tag, " mispred_cnt"}, 32'(bus.mispred_cnt), 32'(mc));
    endtask

    task automatic present(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                           input logic p);
        bus.in_valid   = 1'b1;
        bus.mode       = m;
        bus.data1      = a;
        bus.data2      = b;
        bus.pred_taken = p;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_bc;
        logic [15:0] exp_mc;

        //                mode    data1         data2         pred  taken mis
        vecs[0]  = '{3'b000, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{3'b110, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3'b111, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{3'b001, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{3'b011, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{3'b110, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b011, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{3'b001, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{3'b100, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};

        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.mode = 3'b000; bus.data1 = '0; bus.data2 = '0; bus.pred_taken = 1'b0;
        bus2.in_valid = 1'b0; bus2.stall = 1'b0; bus2.flush = 1'b0;
        bus2.mode = 3'b000; bus2.data1 = '0; bus2.data2 = '0; bus2.pred_taken = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("idle", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        end

        // Back-to-back table of branches, one result per cycle.
        exp_bc = 16'd0;
        exp_mc = 16'd0;
        for (int i = 0; i < 15; i++) begin
            present(vecs[i].mode, vecs[i].d1, vecs[i].d2, vecs[i].pred);
            tick();
            exp_bc = exp_bc + 16'd1;
            if (vecs[i].exp_mis) exp_mc = exp_mc + 16'd1;
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_taken, vecs[i].exp_mis,
                      exp_bc, exp_mc);
        end
        bus.in_valid = 1'b0;
        tick();
        check_out("drain", 1'b0, 1'b0, 1'b0, 16'd15, 16'd7);

        // Multi-cycle stall holds the result while new inputs are presented.
        do_reset();
        present(3'b000, 32'd5, 32'd5, 1'b1);
        tick();
        check_out("stall_load", 1'b1, 1'b1, 1'b0, 16'd1, 16'd0);
        bus.stall = 1'b1;
        present(3'b001, 32'd5, 32'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 16'd1, 16'd0);
        end
        bus.stall = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check_out("stall_release", 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);

        // Flush together with a valid input drops it.
        present(3'b000, 32'd9, 32'd9, 1'b0);
        bus.flush = 1'b1;
        tick();
        check_out("flush_in", 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
        // Flush alone kills a result loaded the cycle before.
        bus.flush = 1'b0;
        present(3'b000, 32'd1, 32'd1, 1'b0);
        tick();
        check_out("pre_flush", 1'b1, 1'b1, 1'b1, 16'd2, 16'd1);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        tick();
        check_out("flush_only", 1'b0, 1'b0, 1'b0, 16'd2, 16'd1);
        // Flush beats stall.
        bus.flush = 1'b0;
        present(3'b001, 32'd1, 32'd2, 1'b1);
        tick();
        check_out("pre_fs", 1'b1, 1'b1, 1'b0, 16'd3, 16'd1);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        tick();
        check_out("flush_stall", 1'b0, 1'b0, 1'b0, 16'd3, 16'd1);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Reset in the middle of a stream.
        present(3'b000, 32'd2, 32'd3, 1'b1);
        tick();
        check_out("stream0", 1'b1, 1'b0, 1'b1, 16'd4, 16'd2);
        present(3'b110, 32'hFFFF_FFF0, 32'd0, 1'b1);
        reset = 1'b1;
        tick();
        check_out("mid_reset", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        reset = 1'b0;
        tick();
        check_out("post_reset", 1'b1, 1'b1, 1'b0, 16'd1, 16'd0);
        bus.in_valid = 1'b0;

        // 2-bit counters: five mispredicted branches saturate both at 3.
        do_reset();
        bus2.in_valid = 1'b1;
        bus2.mode = 3'b000;
        bus2.data1 = 32'd1;
        bus2.data2 = 32'd1;
        bus2.pred_taken = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sat_bc%0d", i), 32'(bus2.branch_cnt), (i > 3) ? 32'd3 : 32'(i));
            check($sformatf("sat_mc%0d", i), 32'(bus2.mispred_cnt), (i > 3) ? 32'd3 : 32'(i));
        end
        check("sat_mispredict", 32'(bus2.mispredict), 32'd1);

        // Mispredict counter keeps climbing while branch_cnt is saturated.
        bus2.in_valid = 1'b0;
        do_reset();
        bus2.in_valid = 1'b1;
        bus2.pred_taken = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("indep_bc", 32'(bus2.branch_cnt), 32'd3);
        check("indep_mc0", 32'(bus2.mispred_cnt), 32'd0);
        bus2.pred_taken = 1'b0;
        tick();
        tick();
        check("indep_bc_sat", 32'(bus2.branch_cnt), 32'd3);
        check("indep_mc2", 32'(bus2.mispred_cnt), 32'd2);
        bus2.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
